// File: rtl/bdeserializer16.sv
// Bit-serial to parallel receiver with valid/ready word output and one word of buffering.
// Optional even-parity bit after the data bits when BDESER_PARITY_EN is defined.
module bdeserializer16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_ssl,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_perr,
    input  logic             out_ready
);

`ifdef BDESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int N  = PAR_EN ? WIDTH + 1 : WIDTH;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic             r_dir;
    logic             r_par;

    logic             w_dir;
    logic             w_last;
    logic             w_data_bit;
    logic [WIDTH-1:0] w_sr_nxt;

    // The first bit of a word shifts with the direction it is latching, not the stale one.
    assign w_dir      = (r_state == IDLE) ? in_ssl : r_dir;
    assign w_sr_nxt   = w_dir ? {r_sr[WIDTH-2:0], in_bit} : {in_bit, r_sr[WIDTH-1:1]};
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_data_bit = (r_cnt < CW'(WIDTH));
    assign in_ready   = (r_state != FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_dir     <= 1'b1;
            r_par     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_perr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dir   <= in_ssl;
                        r_sr    <= w_sr_nxt;
                        r_par   <= in_bit;
                        r_cnt   <= CW'(1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_data_bit) begin
                            r_sr  <= w_sr_nxt;
                            r_par <= r_par ^ in_bit;
                        end
                        if (w_last) begin
                            // Parity bit is the last one and never enters the shift register.
                            r_state   <= FULL;
                            out_valid <= 1'b1;
                            out_data  <= w_data_bit ? w_sr_nxt : r_sr;
                            out_perr  <= PAR_EN ? (r_par ^ in_bit) : 1'b0;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdeserializer16.sv
// Randomized scoreboard bench for bdeserializer16; honours BDESER_PARITY_EN like the design.
module tb_bdeserializer16;
    localparam int W = 16;
`ifdef BDESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_bit, in_ssl, in_ready;
    logic         out_valid, out_perr, out_ready;
    logic [W-1:0] out_data;

    int           n_cmp = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;
    bit           bp_hold = 1'b0;
    logic [W:0]   exp_q[$];

    bdeserializer16 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ssl(in_ssl),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_perr(out_perr), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Consumer: random acceptance, forced off while a backpressure test holds it.
    always @(posedge clk) begin
        #2;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: every presented word must match the scoreboard head until it is consumed.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (in_ready !== !out_valid) begin
                n_err++;
                $display("FAIL ready_vs_valid: in_ready=%b out_valid=%b, required in_ready=%b",
                         in_ready, out_valid, !out_valid);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_word: got data=%h perr=%b, required no word",
                             out_data, out_perr);
                end else begin
                    if ({out_perr, out_data} !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL word: got data=%h perr=%b, required data=%h perr=%b",
                                 out_data, out_perr, exp_q[0][W-1:0], exp_q[0][W]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_bit(input bit b, input bit ssl);
        bit acc;
        int t;
        in_valid = 1'b1;
        in_bit   = b;
        in_ssl   = ssl;
        t        = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 500);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: bit not accepted after %0d cycles, required acceptance", t);
        end
        in_valid = 1'b0;
        in_bit   = $urandom;
    endtask

    // gap: 0 back-to-back, 1 idle cycle before every 3rd bit, 2 random idles.
    task automatic send_word(input logic [W-1:0] w, input bit ssl, input bit pbit,
                             input int gap, input bit flip);
        int  n;
        bit  b, s;
        n = PAR ? W + 1 : W;
        for (int i = 0; i < n; i++) begin
            if ((gap == 1 && i % 3 == 2) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                in_ssl   = $urandom;
                @(posedge clk);
                #1;
            end
            b = (i >= W) ? pbit : (ssl ? w[W-1-i] : w[i]);
            s = (i == 0 || !flip) ? ssl : 1'($urandom);
            send_bit(b, s);
        end
        exp_q.push_back({PAR ? (^w ^ pbit) : 1'b0, w});
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency: out_valid=%b right after last bit, required 1", out_valid);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        logic [W-1:0] w;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_ssl = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_data, out_perr} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b data=%h perr=%b, required 1 0 0000 0",
                     in_ready, out_valid, out_data, out_perr);
        end
        rst = 1'b0;
        mon_en = 1'b1;

        send_word(16'hA5C3, 1'b1, 1'b0, 0, 1'b0);
        send_word(16'h1234, 1'b0, 1'b1, 1, 1'b1);
        drain();

        // Word held under backpressure while the next word's first bit waits.
        bp_hold = 1'b1;
        send_word(16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
        fork
            begin repeat (5) @(posedge clk); bp_hold = 1'b0; end
            send_word(16'h0001, 1'b1, 1'b1, 0, 1'b0);
        join
        drain();

        // Partial word discarded by reset.
        for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        rst = 1'b0;
        send_word(16'h00F0, 1'b1, 1'b0, 0, 1'b0);
        send_word(16'hBEEF, 1'b1, 1'b0, 0, 1'b0);
        send_word(16'hBEEF, 1'b0, 1'b1, 2, 1'b1);
        send_word(16'h0003, 1'b1, 1'b0, 0, 1'b0);
        send_word(16'h0003, 1'b0, 1'b1, 0, 1'b0);
        drain();

        for (int k = 0; k < 150; k++) begin
            w = 16'($urandom);
            send_word(w, 1'($urandom), 1'($urandom), 2, 1'($urandom));
        end
        drain();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
